// File: rtl/lcd_pkg.sv
// Shared constants, types and cursor helpers for the HD44780 bus decoder.
// The optional entry-mode (I/D) feature is enabled by LCD_DECODER_ENTRY_MODE_EN.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_ENTRY     = 8'h04;
   localparam logic [7:0] CMD_DISPLAY   = 8'h08;
   localparam logic [7:0] CMD_SHIFT     = 8'h10;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE0_END  = 7'h27;
   localparam logic [6:0] LINE1_END  = 7'h67;
   localparam logic [6:0] VISIBLE_W  = 7'd16;
   localparam logic [7:0] BLANK_CHAR = 8'h20;
   localparam int         SHADOW_DEPTH = 32;

   typedef enum logic {ST_IDLE, ST_CLEAR} dec_state_e;

   typedef struct packed {
      logic       en;
      logic       rs;
      logic       rw;
      logic [7:0] data;
   } bus_sample_t;

   function automatic logic [6:0] line_offset(input logic [6:0] addr);
      return addr[6] ? addr - LINE1_BASE : addr - LINE0_BASE;
   endfunction

   function automatic logic is_visible(input logic [6:0] addr);
      return line_offset(addr) < VISIBLE_W;
   endfunction

   function automatic logic [4:0] shadow_index(input logic [6:0] addr);
      logic [6:0] off;
      off = line_offset(addr);
      return {addr[6], off[3:0]};
   endfunction

   // Addresses past the end of either line are not backed by DDRAM.
   function automatic logic [6:0] ddram_clamp(input logic [6:0] addr);
      return ((addr & 7'h3F) > LINE0_END) ? LINE0_BASE : addr;
   endfunction

   function automatic logic [6:0] cursor_inc(input logic [6:0] addr);
      if (addr == LINE0_END) return LINE1_BASE;
      if (addr == LINE1_END) return LINE0_BASE;
      return addr + 7'd1;
   endfunction

   function automatic logic [6:0] cursor_dec(input logic [6:0] addr);
      if (addr == LINE0_BASE) return LINE1_END;
      if (addr == LINE1_BASE) return LINE0_END;
      return addr - 7'd1;
   endfunction

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// Raw HD44780 parallel bus as seen by the decoder: the MCU is master, the decoder listens.
interface lcd_bus_decoder_if;
   logic       lcd_en;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   modport master (output lcd_en, lcd_rs, lcd_rw, lcd_data);
   modport slave  (input  lcd_en, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus EN falling-edge detect;
// the third stage holds the bus values from the last cycle EN was high.
module lcd_bus_sync
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   lcd_bus_decoder_if.slave bus,
   output logic             strobe_o,
   output logic             rs_o,
   output logic             rw_o,
   output logic [7:0]       data_o
);

   bus_sample_t raw;
   bus_sample_t s1_q, s2_q, s3_q;

   assign raw = {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data};

   // NOTE: sequential state uses non-blocking assignments so the stages shift in parallel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign strobe_o = s3_q.en & ~s2_q.en;
   assign rs_o     = s3_q.rs;
   assign rw_o     = s3_q.rw;
   assign data_o   = s3_q.data;

endmodule

// File: rtl/lcd_bus_decoder.sv
// HD44780 bus snooper: keeps a 2x16 character shadow, DDRAM cursor and display state.
// Define LCD_DECODER_ENTRY_MODE_EN to honour the entry-mode I/D bit (cursor decrement).
module lcd_bus_decoder
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   lcd_bus_decoder_if.slave bus,
   input  logic [4:0]       rd_addr_i,
   output logic [7:0]       rd_char_o,
   output logic             char_wr_o,
   output logic             cmd_wr_o,
   output logic [7:0]       cmd_code_o,
   output logic [6:0]       cursor_o,
   output logic             display_on_o,
   output logic             busy_o,
   output logic             overrun_o
);

   logic       strobe, st_rs, st_rw;
   logic [7:0] st_data;

   lcd_bus_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .strobe_o (strobe),
      .rs_o     (st_rs),
      .rw_o     (st_rw),
      .data_o   (st_data)
   );

   dec_state_e state_q, state_d;
   logic [4:0] clr_idx_q, clr_idx_d;
   logic [7:0] shadow_q [SHADOW_DEPTH];
   logic [7:0] shadow_d [SHADOW_DEPTH];
   logic [6:0] cursor_q, cursor_d;
   logic [7:0] cmd_code_q, cmd_code_d;
   logic       display_on_q, display_on_d;
   logic       overrun_q, overrun_d;
   logic       char_wr_q, char_wr_d;
   logic       cmd_wr_q, cmd_wr_d;
   logic       incr;

`ifdef LCD_DECODER_ENTRY_MODE_EN
   logic id_q, id_d;
   assign incr = id_q;
`else
   assign incr = 1'b1;
`endif

   // NOTE: every next-state variable gets its default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      shadow_d     = shadow_q;
      cursor_d     = cursor_q;
      cmd_code_d   = cmd_code_q;
      display_on_d = display_on_q;
      overrun_d    = overrun_q;
      char_wr_d    = 1'b0;
      cmd_wr_d     = 1'b0;
`ifdef LCD_DECODER_ENTRY_MODE_EN
      id_d         = id_q;
`endif
      case (state_q)
         ST_CLEAR: begin
            shadow_d[clr_idx_q] = BLANK_CHAR;
            clr_idx_d           = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) state_d = ST_IDLE;
            if (strobe) overrun_d = 1'b1;
         end
         default: begin
            if (strobe && !st_rw) begin
               if (st_rs) begin
                  char_wr_d = 1'b1;
                  if (is_visible(cursor_q)) shadow_d[shadow_index(cursor_q)] = st_data;
                  cursor_d = incr ? cursor_inc(cursor_q) : cursor_dec(cursor_q);
               end else begin
                  cmd_wr_d   = 1'b1;
                  cmd_code_d = st_data;
                  if (st_data >= CMD_SET_DDRAM) begin
                     cursor_d = ddram_clamp(st_data[6:0]);
                  end else if (st_data >= CMD_SHIFT) begin
                     // function set, shift and CGRAM only leave their code behind
                  end else if (st_data >= CMD_DISPLAY) begin
                     display_on_d = st_data[2];
                  end else if (st_data >= CMD_ENTRY) begin
`ifdef LCD_DECODER_ENTRY_MODE_EN
                     id_d = st_data[1];
`endif
                  end else if (st_data >= CMD_HOME) begin
                     cursor_d = LINE0_BASE;
                  end else if (st_data == CMD_CLEAR) begin
                     cursor_d  = LINE0_BASE;
                     clr_idx_d = '0;
                     state_d   = ST_CLEAR;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         clr_idx_q    <= '0;
         cursor_q     <= LINE0_BASE;
         cmd_code_q   <= '0;
         display_on_q <= 1'b0;
         overrun_q    <= 1'b0;
         char_wr_q    <= 1'b0;
         cmd_wr_q     <= 1'b0;
`ifdef LCD_DECODER_ENTRY_MODE_EN
         id_q         <= 1'b1;
`endif
         // NOTE: the shadow is flop-based and must read blank out of reset, so it is reset too.
         for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= BLANK_CHAR;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         cursor_q     <= cursor_d;
         cmd_code_q   <= cmd_code_d;
         display_on_q <= display_on_d;
         overrun_q    <= overrun_d;
         char_wr_q    <= char_wr_d;
         cmd_wr_q     <= cmd_wr_d;
`ifdef LCD_DECODER_ENTRY_MODE_EN
         id_q         <= id_d;
`endif
         shadow_q     <= shadow_d;
      end
   end

   assign rd_char_o    = shadow_q[rd_addr_i];
   assign char_wr_o    = char_wr_q;
   assign cmd_wr_o     = cmd_wr_q;
   assign cmd_code_o   = cmd_code_q;
   assign cursor_o     = cursor_q;
   assign display_on_o = display_on_q;
   assign busy_o       = (state_q == ST_CLEAR);
   assign overrun_o    = overrun_q;

endmodule
